// File: rtl/cout_deskew_pkg.sv
// cout_deskew_pkg: shared defaults (DIM_DEF, BITS_C_DEF) and the collection state type
package cout_deskew_pkg;
  localparam int DIM_DEF = 8;
  localparam int BITS_C_DEF = 16;
  typedef enum logic [1:0] {IDLE, FILL, CAPTURE, FULL} state_e;
endpackage

// File: rtl/cout_deskew_delay.sv
// deskew_delay: DEPTH-stage shift register (clk, rst_n, en shifts, clr empties, din -> dout); DEPTH=0 is a wire
module deskew_delay #(
  parameter int BITS = 16,
  parameter int DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic signed [BITS-1:0] din,
  output logic signed [BITS-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, en, clr};
      assign dout = din;
    end else begin : g_sr
      logic signed [BITS-1:0] sr [DEPTH];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end
      assign dout = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/cout_deskew.sv
// cout_deskew: realigns skewed result wavefronts (clk, rst_n, clr, en, Cin) into DIM stored rows read via Crow -> Cout; busy/full status
module cout_deskew
  import cout_deskew_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM = DIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [BITS_C-1:0] Cin [DIM],
  input  logic [$clog2(DIM)-1:0]   Crow,
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     busy,
  output logic                     full
);
  localparam int CW = $clog2(2*DIM);
  localparam int RW = $clog2(DIM);
  state_e state, nxt;
  logic [CW-1:0] cnt;
  logic acc, wr;
  logic [RW-1:0] row;
  logic signed [BITS_C-1:0] al [DIM];
  logic signed [BITS_C-1:0] mem [DIM][DIM];
  // a beat is taken only while collecting; clr wins over en
  assign acc = en && !clr && state != FULL;
  // beats DIM-1 .. 2*DIM-2 all fall in CAPTURE, each yielding row cnt-(DIM-1)
  assign wr = acc && state == CAPTURE;
  assign row = RW'(cnt - CW'(DIM-1));
  always_comb begin
    nxt = clr ? IDLE :
          !acc ? state :
          (state == IDLE || state == FILL) ? (cnt == CW'(DIM-2) ? CAPTURE : FILL) :
          (cnt == CW'(2*DIM-2)) ? FULL : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= clr ? '0 : acc ? cnt + CW'(1) : cnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) mem[r][c] <= '0;
    end else if (wr) begin
      for (int c = 0; c < DIM; c++) mem[row][c] <= al[c];
    end
  end
  genvar j;
  generate
    for (j = 0; j < DIM; j++) begin : g_col
      deskew_delay #(.BITS(BITS_C), .DEPTH(DIM-1-j)) u_dly (
        .clk(clk), .rst_n(rst_n), .en(acc), .clr(clr), .din(Cin[j]), .dout(al[j])
      );
      assign Cout[j] = mem[Crow][j];
    end
  endgenerate
  assign busy = state == FILL || state == CAPTURE;
  assign full = state == FULL;
endmodule

// File: tb/tb_cout_deskew.sv
// tb_cout_deskew: table-driven check of cout_deskew collection, stall, ignore, clr, reset and signed paths
module tb_cout_deskew;
  localparam int DIM = 8;
  logic clk = 0, rst_n = 0, clr = 0, en = 0;
  logic signed [15:0] Cin [DIM];
  logic [2:0] Crow = '0;
  logic signed [15:0] Cout [DIM];
  logic busy, full;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int start, lat;
  typedef struct {int phase; int crow; int e0; int step;} vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cout_deskew #(.BITS_C(16), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .Cin(Cin),
    .Crow(Crow), .Cout(Cout), .busy(busy), .full(full)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int cval(input int kind, input int r, input int j);
    return kind == 0 ? 16*r + j : kind == 1 ? -32768 + r : -1;
  endfunction
  task automatic drive(input int kind, input int b);
    for (int j = 0; j < DIM; j++) begin
      int r;
      r = b - j;
      Cin[j] = (kind == 2 || (r >= 0 && r < DIM)) ? 16'(cval(kind, r, j)) : 16'sh5a5a;
    end
  endtask
  task automatic beat(input int kind, input int b);
    drive(kind, b);
    en = 1;
    @(posedge clk); #1;
    en = 0;
  endtask
  task automatic idle(input int n);
    en = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic run(input int kind, input int first, input int last);
    for (int b = first; b <= last; b++) beat(kind, b);
  endtask
  task automatic clr_pulse();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask
  task automatic wait_full(input int st, output int l);
    int k;
    k = 0;
    while (!full && k < 30) begin @(posedge clk); #1; k++; end
    l = cyc - st;
  endtask
  task automatic check_phase(input int p, input string name);
    foreach (tbl[k]) if (tbl[k].phase == p) begin
      Crow = 3'(tbl[k].crow);
      #1;
      for (int j = 0; j < DIM; j++)
        chk($sformatf("%s row%0d col%0d", name, tbl[k].crow, j), int'(Cout[j]), tbl[k].e0 + tbl[k].step*j);
    end
  endtask
  initial begin
    for (int r = 0; r < DIM; r++) begin
      tbl.push_back('{0, r, 16*r, 1});
      tbl.push_back('{1, r, 0, 0});
      tbl.push_back('{2, r, r < 2 ? -32768 + r : 16*r, r < 2 ? 0 : 1});
      tbl.push_back('{3, r, -32768 + r, 0});
    end
    for (int j = 0; j < DIM; j++) Cin[j] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset full", int'(full), 0);
    check_phase(1, "reset");
    rst_n = 1;
    idle(1);
    start = cyc;
    run(0, 0, 13);
    chk("run busy before last", int'(busy), 1);
    chk("run full before last", int'(full), 0);
    beat(0, 14);
    chk("run full", int'(full), 1);
    chk("run busy after", int'(busy), 0);
    chk("run latency", cyc - start, 15);
    check_phase(0, "run");
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);
    start = cyc;
    run(0, 0, 5);
    idle(3);
    chk("stall busy", int'(busy), 1);
    run(0, 6, 10);
    idle(2);
    run(0, 11, 13);
    chk("stall full before last", int'(full), 0);
    beat(0, 14);
    wait_full(start, lat);
    chk("stall latency", lat, 20);
    check_phase(0, "stall");
    run(2, 0, 3);
    chk("ignored full", int'(full), 1);
    check_phase(0, "ignored");
    clr_pulse();
    chk("clr from full busy", int'(busy), 0);
    chk("clr from full full", int'(full), 0);
    run(1, 0, 8);
    drive(1, 9);
    en = 1;
    clr = 1;
    @(posedge clk); #1;
    en = 0;
    clr = 0;
    chk("clr beat9 busy", int'(busy), 0);
    chk("clr beat9 full", int'(full), 0);
    check_phase(2, "clr beat9");
    start = cyc;
    run(1, 0, 14);
    chk("signed full", int'(full), 1);
    chk("signed latency", cyc - start, 15);
    check_phase(3, "signed");
    clr_pulse();
    run(0, 0, 6);
    drive(0, 7);
    en = 1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    en = 0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset full", int'(full), 0);
    check_phase(1, "midreset");
    run(0, 0, 14);
    chk("after reset full", int'(full), 1);
    check_phase(0, "after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cout_deskew.md
COUT_DESKEW -- requirements
Module: cout_deskew

Interface
REQ-001 Parameter BITS_C, default 16: signed result element width.
REQ-002 Parameter DIM, default 8: array dimension; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 clr  input  1  synchronous pulse; abandons the current collection and returns to IDLE.
REQ-006 en  input  1  beat valid; Cin is sampled only when en=1.
REQ-007 Cin  input  signed [BITS_C-1:0] x DIM  one skewed result wavefront; Cin[j] carries column j.
REQ-008 Crow  input  $clog2(DIM)  row index for the read port.
REQ-009 Cout  output  signed [BITS_C-1:0] x DIM  stored row Crow; Cout[j] is column j.
REQ-010 busy  output  1  high in FILL or CAPTURE.
REQ-011 full  output  1  high in FULL; all DIM rows are valid.

Function
REQ-012 Input skew: element C[r][j] arrives on Cin[j] at accepted beat r+j; beat numbering starts at 0 with the first en beat after IDLE.
REQ-013 Column j is delayed by DIM-1-j accepted beats; column DIM-1 is undelayed; delay stages advance only on en=1.
REQ-014 At accepted beat b, with DIM-1 <= b <= 2*DIM-2, the aligned wavefront equals row r = b-(DIM-1) and is written to storage row r.
REQ-015 States: IDLE, FILL, CAPTURE, FULL; 2-bit encoding.
REQ-016 IDLE -> FILL on en (beat 0 accepted); FILL -> CAPTURE when beat DIM-2 is accepted; CAPTURE -> FULL when beat 2*DIM-2 is accepted.
REQ-017 Beat counter width is $clog2(2*DIM); it increments only on an accepted beat and clears on entry to IDLE.
REQ-018 In FULL, en is ignored: no storage writes and no delay-line shifts.
REQ-019 en=0 in FILL or CAPTURE stalls all state, counter and delay lines without data loss.
REQ-020 clr=1 forces IDLE next cycle from any state, clears the counter and delay lines, and leaves storage contents unchanged; clr overrides en in the same cycle.
REQ-021 Storage rows not yet written in the current collection hold their previous contents.
REQ-022 Cout is combinational from storage[Crow]; a row written at edge k is visible on Cout after edge k.
REQ-023 busy and full are decoded from registered state; no combinational path from en or clr to them.
REQ-024 No arithmetic on data: values pass unmodified and keep their sign.

Reset
REQ-025 While rst_n=0: state=IDLE, counter=0, all delay stages=0, all storage=0; hence Cout=0, busy=0, full=0.
REQ-026 Reset asserted mid-collection discards everything; after deassertion the block behaves as after power-up.

Structure
REQ-027 A shared package holds the DIM and BITS_C defaults and the state enumeration type.
REQ-028 One sub-module, deskew_delay (parameters BITS, DEPTH; clk, rst_n, en, clr, din, dout), is instantiated once per column with DEPTH=DIM-1-j; DEPTH=0 is a wire.

Verification
REQ-029 DIM=8: drive 15 consecutive en beats with C[r][j]=16*r+j, skewed per REQ-012 -> full rises after beat 14; Cout for Crow=3 reads 48..55.
REQ-030 Same stimulus with en deasserted for 3 cycles after beat 5 and 2 cycles after beat 10 -> identical storage contents; full rises 5 cycles later than in REQ-029.
REQ-031 After full, 4 further en beats with Cin=all -1 -> storage unchanged; full stays 1.
REQ-032 clr together with en at beat 9 -> that beat is discarded; state=IDLE; rows 0..1 keep the new values and rows 2..7 keep their old values; a fresh 15-beat run then fills correctly.
REQ-033 rst_n low for 1 cycle at beat 7 -> next cycle Cout=0 for every Crow, busy=0, full=0.
REQ-034 Signed data: C[r][j] = -32768 + r -> read back exact with sign preserved (BITS_C=16).
